// File: rtl/gcm_pkg.sv
// rtl/gcm_pkg.sv - shared encodings, ctrl bit positions and the AAD tail mask helper
package gcm_pkg;

  localparam int BLK_W = 128;

  localparam int CTRL_INIT    = 0;
  localparam int CTRL_NEXT    = 1;
  localparam int CTRL_ENCDEC  = 2;
  localparam int CTRL_AADONLY = 3;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_LOAD     = 4'd1;
  localparam state_t ST_HKEY_SET = 4'd2;
  localparam state_t ST_HKEY_NXT = 4'd3;
  localparam state_t ST_AAD_RDY  = 4'd4;
  localparam state_t ST_AAD_SET  = 4'd5;
  localparam state_t ST_AAD_NXT  = 4'd6;
  localparam state_t ST_TXT_RDY  = 4'd7;
  localparam state_t ST_TXT_SET  = 4'd8;
  localparam state_t ST_TXT_NXT  = 4'd9;
  localparam state_t ST_LEN_SET  = 4'd10;
  localparam state_t ST_LEN_NXT  = 4'd11;
  localparam state_t ST_WTAG     = 4'd12;
  localparam state_t ST_DONE     = 4'd13;

  // Byte 0 sits in the top byte lane; keep the first rem bytes, all of them when rem is 0.
  function automatic logic [BLK_W-1:0] aad_mask(input logic [3:0] rem);
    logic [BLK_W-1:0] m;
    if (rem == 4'd0) m = {BLK_W{1'b1}};
    else             m = {BLK_W{1'b1}} << (8 * (16 - int'(rem)));
    return m;
  endfunction

endpackage

// File: rtl/gcm_next_pulser.sv
// rtl/gcm_next_pulser.sv - NEXT_HI-high / NEXT_LO-low pulse generator with a done strobe
module gcm_next_pulser
  import gcm_pkg::*;
#(
  parameter int NEXT_HI = 2,
  parameter int NEXT_LO = 2
) (
  input  logic iClk,
  input  logic iRst,
  input  logic start,
  output logic next,
  output logic busy,
  output logic done
);

  localparam int CW = 8;
  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_HI   = 2'd1;
  localparam logic [1:0] PH_LO   = 2'd2;

  logic [1:0]    ph;
  logic [CW-1:0] cnt;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ph  <= PH_IDLE;
      cnt <= '0;
    end else begin
      case (ph)
        PH_IDLE: if (start) begin
          ph  <= PH_HI;
          cnt <= CW'(NEXT_HI - 1);
        end
        PH_HI: if (cnt == '0) begin
          ph  <= PH_LO;
          cnt <= CW'(NEXT_LO - 1);
        end else begin
          cnt <= cnt - CW'(1);
        end
        PH_LO: if (cnt == '0) ph <= PH_IDLE;
               else           cnt <= cnt - CW'(1);
        default: ph <= PH_IDLE;
      endcase
    end
  end

  assign next = (ph == PH_HI);
  assign busy = (ph != PH_IDLE);
  assign done = (ph == PH_LO) && (cnt == '0);

endmodule

// File: rtl/gcm_stream_sequencer.sv
// rtl/gcm_stream_sequencer.sv - turns an AAD/text block stream into the GCM core's pulsed ctrl protocol
module gcm_stream_sequencer
  import gcm_pkg::*;
#(
  parameter int NEXT_HI = 2,
  parameter int NEXT_LO = 2,
  parameter int LEN_W   = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iEncdec,
  input  logic [LEN_W-1:0] iAadBytes,
  input  logic [LEN_W-1:0] iTextBytes,
  input  logic [BLK_W-1:0] iData,
  input  logic             iData_valid,
  output logic             oData_ready,
  output logic [3:0]       oCtrl,
  output logic             oKey_valid,
  output logic             oIV_valid,
  output logic [BLK_W-1:0] oAad,
  output logic             oAad_valid,
  output logic [BLK_W-1:0] oBlock,
  output logic             oBlock_valid,
  input  logic             iCoreReady,
  input  logic [BLK_W-1:0] iResult,
  input  logic             iResult_valid,
  input  logic [BLK_W-1:0] iTag,
  input  logic             iTag_valid,
  input  logic             iAuthentic,
  output logic [BLK_W-1:0] oOut,
  output logic             oOut_valid,
  output logic [BLK_W-1:0] oTag,
  output logic             oTag_valid,
  output logic             oAuthentic,
  output logic             oBusy,
  output logic             oError
);

  localparam int AW   = LEN_W - 3;
  localparam int TW   = LEN_W - 4;
  localparam int LPAD = 64 - LEN_W - 3;

  state_t state_q, state_d;

  logic             encdec_q;
  logic [LEN_W-1:0] aad_bytes_q, text_bytes_q;
  logic [AW-1:0]    a_cnt;
  logic [TW-1:0]    t_cnt;
  logic             text_none_q;
  logic [BLK_W-1:0] aad_q, blk_q;
  logic             evt_seen, ready_q, resv_q;

  logic             pul_start, pul_next, pul_busy, pul_done;
  logic             idle_like, bad_len, a_last;
  logic             ready_rise, resv_rise;
  logic             aad_step_done, txt_step_done;
  logic [LEN_W:0]   aad_ext;
  logic [BLK_W-1:0] lenblk;
  state_t           after_hkey, after_aad;

  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bad_len    = (iTextBytes[3:0] != 4'd0);
  assign aad_ext    = {1'b0, iAadBytes} + (LEN_W + 1)'(15);
  assign a_last     = (a_cnt == AW'(1));
  assign ready_rise = iCoreReady & ~ready_q;
  assign resv_rise  = iResult_valid & ~resv_q;
  assign lenblk     = {{LPAD{1'b0}}, aad_bytes_q, 3'b000, {LPAD{1'b0}}, text_bytes_q, 3'b000};

  assign pul_start = (state_q == ST_HKEY_SET) || (state_q == ST_AAD_SET) ||
                     (state_q == ST_TXT_SET)  || (state_q == ST_LEN_SET);

  // HKEY and TEXT steps finish only once both the pulse and the core's response are over.
  assign aad_step_done = (state_q == ST_AAD_NXT) && pul_done;
  assign txt_step_done = (state_q == ST_TXT_NXT) && !pul_busy && evt_seen;

  assign after_aad  = (t_cnt != '0) ? ST_TXT_RDY : ST_LEN_SET;
  assign after_hkey = (a_cnt != '0) ? ST_AAD_RDY : after_aad;

  gcm_next_pulser #(
    .NEXT_HI (NEXT_HI),
    .NEXT_LO (NEXT_LO)
  ) u_pulser (
    .iClk  (iClk),
    .iRst  (iRst),
    .start (pul_start),
    .next  (pul_next),
    .busy  (pul_busy),
    .done  (pul_done)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iStart && !bad_len) state_d = ST_LOAD;
        else                    state_d = ST_IDLE;
      end
      ST_LOAD:     state_d = ST_HKEY_SET;
      ST_HKEY_SET: state_d = ST_HKEY_NXT;
      ST_HKEY_NXT: if (!pul_busy && evt_seen) state_d = after_hkey;
      ST_AAD_RDY:  if (iData_valid) state_d = ST_AAD_SET;
      ST_AAD_SET:  state_d = ST_AAD_NXT;
      ST_AAD_NXT:  if (pul_done) state_d = a_last ? after_aad : ST_AAD_RDY;
      ST_TXT_RDY:  if (iData_valid) state_d = ST_TXT_SET;
      ST_TXT_SET:  state_d = ST_TXT_NXT;
      ST_TXT_NXT:  if (txt_step_done) state_d = (t_cnt == TW'(1)) ? ST_LEN_SET : ST_TXT_RDY;
      ST_LEN_SET:  state_d = ST_LEN_NXT;
      ST_LEN_NXT:  if (pul_done) state_d = ST_WTAG;
      ST_WTAG:     if (iTag_valid) state_d = ST_DONE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    oCtrl        = '0;
    oKey_valid   = 1'b0;
    oIV_valid    = 1'b0;
    oAad         = aad_q;
    oAad_valid   = 1'b0;
    oBlock       = blk_q;
    oBlock_valid = 1'b0;
    oData_ready  = 1'b0;
    oBusy        = !idle_like;
    oCtrl[CTRL_NEXT]   = pul_next;
    oCtrl[CTRL_ENCDEC] = encdec_q;
    case (state_q)
      ST_LOAD: begin
        oKey_valid = 1'b1;
        oIV_valid  = 1'b1;
      end
      ST_HKEY_SET, ST_HKEY_NXT, ST_WTAG: oCtrl[CTRL_INIT] = 1'b1;
      ST_AAD_RDY, ST_TXT_RDY: begin
        oCtrl[CTRL_INIT] = 1'b1;
        oData_ready      = 1'b1;
      end
      ST_AAD_SET, ST_AAD_NXT: begin
        oCtrl[CTRL_INIT] = 1'b1;
        oAad_valid       = 1'b1;
      end
      ST_TXT_SET, ST_TXT_NXT: begin
        oCtrl[CTRL_INIT] = 1'b1;
        oBlock_valid     = 1'b1;
      end
      ST_LEN_SET, ST_LEN_NXT: begin
        oCtrl[CTRL_INIT]    = 1'b1;
        oCtrl[CTRL_AADONLY] = text_none_q;
        oAad                = lenblk;
        oAad_valid          = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      encdec_q     <= 1'b0;
      aad_bytes_q  <= '0;
      text_bytes_q <= '0;
      a_cnt        <= '0;
      t_cnt        <= '0;
      text_none_q  <= 1'b0;
      aad_q        <= '0;
      blk_q        <= '0;
      evt_seen     <= 1'b0;
      ready_q      <= 1'b0;
      resv_q       <= 1'b0;
      oOut         <= '0;
      oOut_valid   <= 1'b0;
      oTag         <= '0;
      oTag_valid   <= 1'b0;
      oAuthentic   <= 1'b0;
      oError       <= 1'b0;
    end else begin
      ready_q    <= iCoreReady;
      resv_q     <= iResult_valid;
      oOut_valid <= 1'b0;

      if (idle_like && iStart) begin
        oError <= bad_len;
        if (!bad_len) begin
          encdec_q     <= iEncdec;
          aad_bytes_q  <= iAadBytes;
          text_bytes_q <= iTextBytes;
          a_cnt        <= aad_ext[LEN_W:4];
          t_cnt        <= iTextBytes[LEN_W-1:4];
          text_none_q  <= (iTextBytes[LEN_W-1:4] == '0);
          oTag_valid   <= 1'b0;
          oAuthentic   <= 1'b0;
        end
      end

      if (state_q == ST_AAD_RDY && iData_valid)
        aad_q <= iData & (a_last ? aad_mask(aad_bytes_q[3:0]) : {BLK_W{1'b1}});
      if (state_q == ST_TXT_RDY && iData_valid)
        blk_q <= iData;

      if (aad_step_done) a_cnt <= a_cnt - AW'(1);
      if (txt_step_done) t_cnt <= t_cnt - TW'(1);

      // The core may answer while next is still high, so the response is latched, not waited on.
      case (state_q)
        ST_HKEY_SET, ST_TXT_SET: evt_seen <= 1'b0;
        ST_HKEY_NXT: if (ready_rise) evt_seen <= 1'b1;
        ST_TXT_NXT:  if (resv_rise)  evt_seen <= 1'b1;
        default: ;
      endcase

      if (state_q == ST_TXT_NXT && resv_rise && !evt_seen) begin
        oOut       <= iResult;
        oOut_valid <= 1'b1;
      end

      if (state_q == ST_WTAG && iTag_valid) begin
        oTag       <= iTag;
        oTag_valid <= 1'b1;
        oAuthentic <= iAuthentic & ~encdec_q;
      end
    end
  end

endmodule

// File: tb/tb_gcm_stream_sequencer.sv
// tb/tb_gcm_stream_sequencer.sv - directed bench for gcm_stream_sequencer with a behavioural core model
module tb_gcm_stream_sequencer;

  localparam logic [127:0] A0   = 128'hfeedfacedeadbeeffeedfacedeadbeef;
  localparam logic [127:0] A1   = 128'habaddad2111111112222222233333333;
  localparam logic [127:0] A1M  = 128'habaddad2000000000000000000000000;
  localparam logic [127:0] P0   = 128'hd9313225f88406e5a55909c5aff5269a;
  localparam logic [127:0] P1   = 128'h86a7a9531534f7da2e4c303d8a318a72;
  localparam logic [127:0] C4   = 128'h42831ec2217774244b7221b784d0d49c;
  localparam logic [127:0] LEN2 = 128'h00000000000000a0_0000000000000100;
  localparam logic [127:0] LEN4 = 128'h0000000000000080_0000000000000080;
  localparam logic [127:0] EK0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;

  logic         iClk = 1'b0;
  logic         iRst = 1'b1;
  logic         iStart = 1'b0;
  logic         iEncdec = 1'b0;
  logic [15:0]  iAadBytes = '0;
  logic [15:0]  iTextBytes = '0;
  logic [127:0] iData = '0;
  logic         iData_valid = 1'b0;
  logic         iCoreReady = 1'b1;
  logic [127:0] iResult = '0;
  logic         iResult_valid = 1'b0;
  logic [127:0] iTag = '0;
  logic         iTag_valid = 1'b0;
  logic         iAuthentic = 1'b0;
  logic         oData_ready, oKey_valid, oIV_valid, oAad_valid, oBlock_valid;
  logic         oOut_valid, oTag_valid, oAuthentic, oBusy, oError;
  logic [3:0]   oCtrl;
  logic [127:0] oAad, oBlock, oOut, oTag;

  gcm_stream_sequencer #(.NEXT_HI(2), .NEXT_LO(2), .LEN_W(16)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iEncdec(iEncdec),
    .iAadBytes(iAadBytes), .iTextBytes(iTextBytes), .iData(iData),
    .iData_valid(iData_valid), .oData_ready(oData_ready), .oCtrl(oCtrl),
    .oKey_valid(oKey_valid), .oIV_valid(oIV_valid), .oAad(oAad),
    .oAad_valid(oAad_valid), .oBlock(oBlock), .oBlock_valid(oBlock_valid),
    .iCoreReady(iCoreReady), .iResult(iResult), .iResult_valid(iResult_valid),
    .iTag(iTag), .iTag_valid(iTag_valid), .iAuthentic(iAuthentic),
    .oOut(oOut), .oOut_valid(oOut_valid), .oTag(oTag), .oTag_valid(oTag_valid),
    .oAuthentic(oAuthentic), .oBusy(oBusy), .oError(oError)
  );

  initial forever #5 iClk = ~iClk;

  logic [525:0] all_o;
  assign all_o = {oData_ready, oCtrl, oKey_valid, oIV_valid, oAad, oAad_valid, oBlock,
                  oBlock_valid, oOut, oOut_valid, oTag, oTag_valid, oAuthentic, oBusy, oError};

  function automatic logic [127:0] mix(input logic [127:0] g, input logic [127:0] x);
    return {g[126:0], g[127]} ^ x;
  endfunction

  function automatic logic [127:0] ks(input int i);
    return 128'h0123456789abcdeffedcba9876543210 + 128'(i);
  endfunction

  // Behavioural core: next-rise driven, fixed response latencies, toy GHASH over what it is fed.
  logic [127:0] aad_log[$];
  logic [3:0]   ctrl_log[$];
  logic [127:0] out_log[$];
  logic [127:0] g, res_val, mdl_ref_tag;
  int           rdy_cnt, res_cnt, tag_cnt, aad_steps, blk_idx, mdl_aad_exp, key_loads;
  bit           prev_next;

  always @(negedge iClk) begin
    if (iRst) begin
      iCoreReady = 1'b1; iResult_valid = 1'b0; iTag_valid = 1'b0; iAuthentic = 1'b0;
      rdy_cnt = 0; res_cnt = 0; tag_cnt = 0; aad_steps = 0; blk_idx = 0;
      prev_next = 1'b0; g = '0;
    end else begin
      iResult_valid = 1'b0;
      iTag_valid    = 1'b0;
      if (rdy_cnt > 0) begin rdy_cnt--; if (rdy_cnt == 0) iCoreReady = 1'b1; end
      if (res_cnt > 0) begin
        res_cnt--;
        if (res_cnt == 0) begin iResult = res_val; iResult_valid = 1'b1; end
      end
      if (tag_cnt > 0) begin
        tag_cnt--;
        if (tag_cnt == 0) begin
          iTag = g ^ EK0; iTag_valid = 1'b1; iAuthentic = ((g ^ EK0) == mdl_ref_tag);
        end
      end
      if (oKey_valid && oIV_valid) begin key_loads++; aad_steps = 0; blk_idx = 0; end
      if (oOut_valid) out_log.push_back(oOut);
      if (oCtrl[1] && !prev_next) begin
        if (oAad_valid) begin
          aad_log.push_back(oAad); ctrl_log.push_back(oCtrl);
          g = mix(g, oAad); aad_steps++;
          if (aad_steps == mdl_aad_exp) tag_cnt = 9;
        end else if (oBlock_valid) begin
          res_val = oBlock ^ ks(blk_idx); blk_idx++;
          g = mix(g, oCtrl[2] ? res_val : oBlock);
          res_cnt = 7;
        end else begin
          iCoreReady = 1'b0; rdy_cnt = 6; g = '0;
        end
      end
      prev_next = oCtrl[1];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [127:0] words[4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_msg(input bit enc, input int aad, input int txt);
    @(negedge iClk);
    iEncdec = enc; iAadBytes = 16'(aad); iTextBytes = 16'(txt); iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input bit gaps);
    for (int i = first; i < last; i++) begin
      int cyc;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge iClk);
      iData = words[i]; iData_valid = 1'b1;
      cyc = 0;
      while (!oData_ready && cyc < 400) begin @(negedge iClk); cyc++; end
      if (cyc >= 400) chk("feed_ready_timeout", 128'(oData_ready), 128'd1);
      @(posedge iClk); #1;
      iData_valid = 1'b0;
    end
  endtask

  task automatic clear_logs();
    aad_log.delete(); ctrl_log.delete(); out_log.delete(); key_loads = 0;
  endtask

  task automatic run_msg(input bit enc, input int aad, input int txt, input int nw,
                         input bit gaps, input bit dup_start);
    int cyc;
    clear_logs();
    mdl_aad_exp = (aad + 15) / 16 + 1;
    start_msg(enc, aad, txt);
    if (dup_start) begin
      feed(0, 1, gaps);
      @(negedge iClk);
      iEncdec = 1'b0; iAadBytes = 16'd0; iTextBytes = 16'd16; iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      feed(1, nw, gaps);
    end else begin
      feed(0, nw, gaps);
    end
    cyc = 0;
    while (!oTag_valid && cyc < 2000) begin @(negedge iClk); cyc++; end
    chk("tag_valid_seen", 128'(oTag_valid), 128'd1);
    repeat (3) @(negedge iClk);
  endtask

  task automatic check_t2(input string p, input logic [127:0] t2_tag);
    chk({p, "_aad_count"}, 128'(aad_log.size()), 128'd3);
    chk({p, "_aad0"}, aad_log[0], A0);
    chk({p, "_aad1_masked"}, aad_log[1], A1M);
    chk({p, "_lenblk"}, aad_log[2], LEN2);
    chk({p, "_ctrl_aad"}, 128'(ctrl_log[0]), 128'h7);
    chk({p, "_ctrl_len"}, 128'(ctrl_log[2]), 128'h7);
    chk({p, "_out_count"}, 128'(out_log.size()), 128'd2);
    chk({p, "_out0"}, out_log[0], P0 ^ ks(0));
    chk({p, "_out1"}, out_log[1], P1 ^ ks(1));
    chk({p, "_tag"}, oTag, t2_tag);
    chk({p, "_auth_enc"}, 128'(oAuthentic), 128'd0);
    chk({p, "_busy_err"}, 128'({oBusy, oError}), 128'd0);
    chk({p, "_key_loads"}, 128'(key_loads), 128'd1);
  endtask

  initial begin
    logic [127:0] t2_tag, t4_tag;
    int           cyc;
    bit           busy_seen;

    t2_tag = EK0 ^ mix(mix(mix(mix(mix('0, A0), A1M), P0 ^ ks(0)), P1 ^ ks(1)), LEN2);
    t4_tag = EK0 ^ mix(mix(mix('0, A0), C4), LEN4);
    mdl_ref_tag = '0;
    mdl_aad_exp = 1;
    key_loads = 0;

    @(negedge iClk);
    assert (all_o === '0) else begin
      n_fail++;
      $error("FAIL reset_outputs: observed %h expected 0", all_o);
    end
    n_chk++;
    @(negedge iClk);
    iRst = 1'b0;
    repeat (2) @(negedge iClk);

    // T5: text length not a multiple of 16
    clear_logs();
    start_msg(1'b1, 0, 17);
    busy_seen = 1'b0;
    repeat (10) begin @(negedge iClk); busy_seen |= oBusy; end
    chk("t5_error", 128'(oError), 128'd1);
    chk("t5_never_busy", 128'(busy_seen), 128'd0);
    chk("t5_no_core_activity", 128'(key_loads + aad_log.size()), 128'd0);

    // T2: encrypt, 20-byte AAD, 32-byte text
    words[0] = A0; words[1] = A1; words[2] = P0; words[3] = P1;
    mdl_ref_tag = t2_tag;
    run_msg(1'b1, 20, 32, 4, 1'b0, 1'b0);
    check_t2("t2", t2_tag);

    // T3: empty AAD and text
    mdl_ref_tag = '0;
    run_msg(1'b1, 0, 0, 0, 1'b0, 1'b0);
    chk("t3_aad_count", 128'(aad_log.size()), 128'd1);
    chk("t3_lenblk_zero", aad_log[0], 128'd0);
    chk("t3_ctrl_aadonly", 128'(ctrl_log[0]), 128'hf);
    chk("t3_no_out", 128'(out_log.size()), 128'd0);
    chk("t3_tag", oTag, EK0);

    // T4: decrypt with matching and with corrupted reference tag
    words[0] = A0; words[1] = C4;
    mdl_ref_tag = t4_tag;
    run_msg(1'b0, 16, 16, 2, 1'b0, 1'b0);
    chk("t4_aad0_unmasked", aad_log[0], A0);
    chk("t4_lenblk", aad_log[1], LEN4);
    chk("t4_ctrl_len", 128'(ctrl_log[1]), 128'h3);
    chk("t4_out0", out_log[0], C4 ^ ks(0));
    chk("t4_tag", oTag, t4_tag);
    chk("t4_authentic", 128'(oAuthentic), 128'd1);
    mdl_ref_tag = t4_tag ^ (128'd1 << 77);
    run_msg(1'b0, 16, 16, 2, 1'b0, 1'b0);
    chk("t4b_tag", oTag, t4_tag);
    chk("t4b_not_authentic", 128'(oAuthentic), 128'd0);

    // T6: gapped stream plus a stray start while busy
    words[0] = A0; words[1] = A1; words[2] = P0; words[3] = P1;
    mdl_ref_tag = t2_tag;
    run_msg(1'b1, 20, 32, 4, 1'b1, 1'b1);
    check_t2("t6", t2_tag);

    // T1: asynchronous reset in the middle of the text phase, then a clean rerun
    clear_logs();
    mdl_aad_exp = 3;
    start_msg(1'b1, 20, 32);
    feed(0, 3, 1'b0);
    cyc = 0;
    while (!oBlock_valid && cyc < 200) begin @(negedge iClk); cyc++; end
    chk("t1_in_text", 128'(oBlock_valid), 128'd1);
    #2 iRst = 1'b1;
    #1;
    assert (all_o === '0) else begin
      n_fail++;
      $error("FAIL t1_reset_outputs: observed %h expected 0", all_o);
    end
    n_chk++;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    repeat (2) @(negedge iClk);
    run_msg(1'b1, 20, 32, 4, 1'b0, 1'b0);
    check_t2("t1_rerun", t2_tag);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
